// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the SRAM-like req/addr_ok/data_ok bus.
// Data has priority; an in-order owner FIFO routes each data_ok back to its issuer.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned PTR_W           = 2
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // slave port
  output logic        slv_req,
  output logic        slv_wr,
  output logic [1:0]  slv_size,
  output logic [31:0] slv_addr,
  output logic [3:0]  slv_wstrb,
  output logic [31:0] slv_wdata,
  input  logic        slv_addr_ok,
  input  logic        slv_data_ok,
  input  logic [31:0] slv_rdata
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_e;

  lock_state_e                state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  grant_e grant;
  logic   fifo_full;
  logic   fifo_empty;
  logic   req_c;
  logic   push;
  logic   pop;
  logic   head_is_data;

  // A locked owner keeps the grant until its pending request is accepted.
  always_comb begin
    grant = GNT_NONE;
    case (state_q)
      ST_LOCK_INST: grant = GNT_INST;
      ST_LOCK_DATA: grant = GNT_DATA;
      default: begin
        if (data_req)      grant = GNT_DATA;
        else if (inst_req) grant = GNT_INST;
      end
    endcase
  end

  assign fifo_full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty   = (cnt_q == '0);
  assign req_c        = !reset && (grant != GNT_NONE) && !fifo_full;
  assign push         = req_c && slv_addr_ok;
  assign pop          = !reset && slv_data_ok && !fifo_empty;
  assign head_is_data = owner_q[rd_ptr_q];

  // Request payload to the slave, from whichever master holds the grant.
  always_comb begin
    slv_req   = req_c;
    slv_wr    = inst_wr;
    slv_size  = inst_size;
    slv_addr  = inst_addr;
    slv_wstrb = inst_wstrb;
    slv_wdata = inst_wdata;
    if (grant == GNT_DATA) begin
      slv_wr    = data_wr;
      slv_size  = data_size;
      slv_addr  = data_addr;
      slv_wstrb = data_wstrb;
      slv_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = push && (grant == GNT_INST);
  assign data_addr_ok = push && (grant == GNT_DATA);
  assign inst_data_ok = pop && !head_is_data;
  assign data_data_ok = pop && head_is_data;
  assign inst_rdata   = slv_rdata;
  assign data_rdata   = slv_rdata;

  // Lock FSM and owner FIFO next-state.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    if (req_c) begin
      if (slv_addr_ok)           state_d = ST_IDLE;
      else if (grant == GNT_DATA) state_d = ST_LOCK_DATA;
      else                        state_d = ST_LOCK_INST;
    end

    if (push) begin
      owner_d[wr_ptr_q] = (grant == GNT_DATA);
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
